// File: rtl/div_pkg.sv
// Shared types and defaults for the radix-2 restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;
endpackage

// File: rtl/div_radix2_if.sv
// Request/response handshake bundle between the EXE stage and the divider.
interface div_radix2_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             div_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             busy;

  modport master (
    output flush, in_valid, div_signed, x, y, out_ready,
    input  in_ready, out_valid, s, r, busy
  );

  modport slave (
    input  flush, in_valid, div_signed, x, y, out_ready,
    output in_ready, out_valid, s, r, busy
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring step: shift in the next dividend bit, subtract divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q
);
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;

  // rem < dvs on entry, so both the difference and the kept value fit in WIDTH bits
  assign t        = {rem, din};
  assign q        = (t >= {1'b0, dvs});
  assign diff     = t[WIDTH-1:0] - dvs;
  assign rem_next = q ? diff : t[WIDTH-1:0];
endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider: WIDTH CALC steps, one sign-fix cycle, then hold until taken.
module div_radix2
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         div_clk,
  input  logic         resetn,
  div_radix2_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic             sgn, x_neg, y_neg;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] ax, ay;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             out_valid;
  logic [WIDTH-1:0] s_q, r_q;

  assign bus.in_ready  = (state == IDLE) & ~bus.flush;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid;
  assign bus.s         = s_q;
  assign bus.r         = r_q;

  assign ax = (bus.div_signed & bus.x[WIDTH-1]) ? -bus.x : bus.x;
  assign ay = (bus.div_signed & bus.y[WIDTH-1]) ? -bus.y : bus.y;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .din      (dvd[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (rem_nxt),
    .q        (q_bit)
  );

  // dvd has been fully replaced by the quotient by the time FIX runs.
  // Signed /0 would otherwise come out as +1 for negative x, hence the override.
  always_comb begin
    q_fix = (sgn & (x_neg ^ y_neg)) ? -dvd : dvd;
    r_fix = (sgn & x_neg) ? -rem : rem;
    if (sgn && dvs == '0) q_fix = '1;
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      sgn       <= 1'b0;
      x_neg     <= 1'b0;
      y_neg     <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      s_q       <= '0;
      r_q       <= '0;
    end else if (bus.flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sgn   <= bus.div_signed;
          x_neg <= bus.div_signed & bus.x[WIDTH-1];
          y_neg <= bus.div_signed & bus.y[WIDTH-1];
          dvd   <= ax;
          dvs   <= ay;
          rem   <= '0;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          s_q       <= q_fix;
          r_q       <= r_fix;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_radix2.sv
// Randomized + directed bench for div_radix2 against an arithmetic reference model.
module tb_div_radix2;
  localparam int W = 32;

  logic div_clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] prev_s, prev_r;

  div_radix2_if #(.WIDTH(W)) bus ();

  div_radix2 #(.WIDTH(W)) dut (
    .div_clk (div_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Truncating division, remainder follows the dividend; /0 gives all ones and x.
  function automatic void model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] rm);
    longint sa, sb, qq, rr;
    if (b == 0) begin
      q  = '1;
      rm = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[W-1:0];
      rm = rr[W-1:0];
    end else begin
      q  = a / b;
      rm = a % b;
    end
  endfunction

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic start_op(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    int w = 0;
    while (!bus.in_ready && w < 100) begin
      tick();
      w++;
    end
    chk("accept_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.div_signed = sg;
    bus.x          = a;
    bus.y          = b;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.x          = $urandom;
    bus.y          = $urandom;
    bus.div_signed = $urandom_range(0, 1);
  endtask

  task automatic run_op(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq, er;
    int cyc = 0;
    int bad_rdy = 0;
    model(sg, a, b, eq, er);
    start_op(sg, a, b);
    while (!bus.out_valid && cyc < 100) begin
      if (bus.in_ready || !bus.busy) bad_rdy++;
      tick();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd33);
    chk("ready_low_in_calc", 64'(bad_rdy), 64'd0);
    chk($sformatf("s %s %h/%h", sg ? "sgn" : "uns", a, b), 64'(bus.s), 64'(eq));
    chk($sformatf("r %s %h/%h", sg ? "sgn" : "uns", a, b), 64'(bus.r), 64'(er));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_s", 64'(bus.s), 64'(eq));
      chk("hold_r", 64'(bus.r), 64'(er));
      chk("hold_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("post_hs_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("post_hs_ready", {63'd0, bus.in_ready}, 64'd1);
    prev_s = eq;
    prev_r = er;
  endtask

  initial begin
    int rises;
    logic [W-1:0] a, b;
    bit sg;
    resetn        = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.div_signed = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.out_ready = 1'b0;
    prev_s        = '0;
    prev_r        = '0;
    repeat (3) tick();
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_s", 64'(bus.s), 64'd0);
    chk("rst_r", 64'(bus.r), 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    resetn = 1'b1;
    tick();
    chk("idle_ready", {63'd0, bus.in_ready}, 64'd1);

    // Directed cases from the arithmetic corners
    run_op(1'b0, 32'd7, 32'd2, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'h0000_1234, 32'd0, 0);
    run_op(1'b1, 32'hFFFF_FF00, 32'd0, 0);
    run_op(1'b1, 32'h8000_0000, 32'd0, 0);
    run_op(1'b1, 32'h0000_0055, 32'd0, 0);
    run_op(1'b0, 32'hDEAD_BEEF, 32'd13, 5);
    run_op(1'b0, 32'd100, 32'd9, 0);

    // Flush mid-CALC with a competing request in the same cycle
    start_op(1'b0, 32'hFFFF_0000, 32'd3);
    repeat (10) tick();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    chk("flush_blocks_ready", {63'd0, bus.in_ready}, 64'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_idle", {63'd0, bus.busy}, 64'd0);
    chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_keep_s", 64'(bus.s), 64'(prev_s));
    chk("flush_keep_r", 64'(bus.r), 64'(prev_r));
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid || bus.busy) rises++;
    end
    chk("flush_no_result", 64'(rises), 64'd0);

    // Asynchronous reset mid-CALC
    start_op(1'b1, 32'hFFFF_1234, 32'd77);
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    chk("arst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("arst_s", 64'(bus.s), 64'd0);
    chk("arst_r", 64'(bus.r), 64'd0);
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    run_op(1'b0, 32'd100, 32'd7, 0);

    // Random operands, biased toward zero, -1 and MIN corners
    for (int n = 0; n < 200; n++) begin
      sg = $urandom_range(0, 1);
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = '1;
        2: a = 32'h8000_0000;
        3: begin a = 32'h8000_0000; b = '1; end
        4: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(sg, a, b, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
